pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch front end of the five-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It issues single-outstanding requests to the instruction memory and absorbs memory wait states and pipeline stalls. It applies branch redirects (preserving the delay slot) and exception flushes, and delivers one registered `{if_pc, if_inst}` pair per accepted instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high; clock `clk`.
- `stall` input `StopBus` (6): pipeline stall vector; only bit 0 (PC stage hold) is used here.
- `branch_flag` input 1: single-cycle pulse from ID in a cycle where ID advances; redirect after the delay slot.
- `branch_target` input 32: target that accompanies `branch_flag`.
- `flush` input 1: exception/ERET flush; highest priority.
- `new_pc` input 32: restart address that accompanies `flush`.
- `inst_req` output 1: fetch request; held high until `inst_ack`.
- `inst_addr` output 32: fetch address; stable while `inst_req`=1.
- `inst_ack` input 1: memory completion; may arrive in the same cycle as `inst_req` (zero wait).
- `inst_rdata` input 32: instruction word; valid only with `inst_ack`.
- `if_pc` output 32: registered PC of the delivered instruction.
- `if_inst` output 32: registered delivered instruction; 0 (NOP) on a bubble.
- `stallreq_if` output 1: combinational `inst_req & ~inst_ack` in FETCH; requests a pipeline stall.

## Operation
- Registers: `pc`, `pend_valid`/`pend_target` (latched branch), `buf_inst`/`buf_pc` (hold buffer), 2-bit state.
- States:
  - IDLE: `inst_req`=0. Always moves to FETCH next cycle.
  - FETCH: `inst_req`=1, `inst_addr`=`pc`.
  - DISCARD: `inst_req`=1 on the old address; the response is dropped.
  - HOLD: `inst_req`=0; `buf_inst` carries the instruction captured while stalled.
- Next-PC selection on delivery: `pend_valid ? pend_target : pc+4`. Addition wraps modulo 2^32. `pend_valid` clears when consumed. No alignment check is done here.
- `branch_flag` sets `pend_valid`/`pend_target`. If it coincides with a delivering `inst_ack`, `branch_target` is used directly as next PC; that acked instruction is the delay slot and is kept.
- FETCH with `inst_ack` and `stall[0]`=0:
  - Outputs load `{pc, inst_rdata}`.
  - `pc` advances.
  - State stays FETCH, giving back-to-back requests at 1 instruction/cycle with zero-wait memory.
- FETCH with `inst_ack` and `stall[0]`=1: capture into `buf_*`, go to HOLD. Outputs hold.
- HOLD:
  - When `stall[0]`=0, outputs load `buf_*`, `pc` advances, go to FETCH.
  - If `stall[0]` stays 1, HOLD persists with no request.
- FETCH without `inst_ack`: outputs become a bubble (`if_pc`=0, `if_inst`=0) unless `stall[0]`=1, in which case they hold.
- `flush` beats `branch_flag`, beats normal advance:
  - `pc`←`new_pc`; `pend_valid` and `buf_*` are cleared; outputs become a bubble.
  - From FETCH without ack: go to DISCARD.
  - From FETCH with ack, from HOLD, or from IDLE: go to FETCH at `new_pc`.
- DISCARD:
  - On `inst_ack`, drop the data and go to FETCH.
  - A new `flush` during DISCARD only overwrites `pc`.
  - `branch_flag` during DISCARD is ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, state IDLE, `pend_valid`=0, `if_pc`=0, `if_inst`=0, `inst_req`=0, `stallreq_if`=0, `inst_addr`=`RESET_PC`.
- First `inst_req` is the 2nd cycle after `rst` deasserts.
- Latency: `inst_ack` in cycle N → `if_pc`/`if_inst` valid in cycle N+1.
- `stallreq_if` rises in the same cycle as an un-acked FETCH request. It is 0 in IDLE, HOLD and DISCARD.
- `rst` mid-request: the abandoned response is the memory's responsibility; the block returns to IDLE and ignores `inst_ack` that cycle.
- `flush` and `inst_ack` in the same cycle: the data is dropped and the next request is to `new_pc` in cycle N+1.

## Structure
- `defines.v` gains the state encodings `FetchIdle`/`FetchReq`/`FetchDiscard`/`FetchHold` and `NopInst` (32'h0).
- It reuses `ZeroWord`, `InstAddrBus`, `InstBus`, `StopBus`, `Stop`/`NoStop`.
- Single module with no sub-module; the hold buffer is a plain register pair.

## Test plan
- Reset release, zero-wait memory (`inst_ack` tied to `inst_req`) → requests to 0x0, 0x4, 0x8 in consecutive cycles; `if_pc` follows one cycle later; `stallreq_if`=0.
- Memory with 2 wait states → `stallreq_if`=1 for 2 cycles per fetch; `inst_addr` stable; `if_inst`=0 on bubble cycles.
- `branch_flag`, target 0x100, pulsed while fetching 0x8 → 0x8 delivered (delay slot); next request is 0x100.
- `stall[0]`=1 for 3 cycles when 0xC is acked → HOLD with no requests; 0xC appears on `if_pc` the cycle after the stall drops, then the request for 0x10 is issued.
- `flush` with `new_pc`=0x180 during a pending 2-wait fetch → DISCARD; the old data is dropped; the next request is 0x180; the pending branch is cleared.
- `rst` asserted mid-request → all outputs are at reset values next cycle; the first request is again `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types, encodings and helpers for the instruction-fetch front end.
package pc_fetch_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned STOP_W      = 6;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   localparam inst_addr_t ZeroWord = '0;
   localparam inst_t      NopInst  = '0;
   localparam logic       Stop     = 1'b1;

   typedef enum logic [1:0] {
      FetchIdle    = 2'd0,
      FetchReq     = 2'd1,
      FetchDiscard = 2'd2,
      FetchHold    = 2'd3
   } fetch_state_t;

   typedef struct packed {
      inst_addr_t pc;
      inst_t      inst;
   } fetch_pair_t;

   // A branch arriving with the delivering ack wins over an older latched one.
   function automatic inst_addr_t select_next_pc(
      input logic       branch_flag,
      input inst_addr_t branch_target,
      input logic       pend_valid,
      input inst_addr_t pend_target,
      input inst_addr_t pc
   );
      if (branch_flag) return branch_target;
      if (pend_valid)  return pend_target;
      return inst_addr_t'(pc + INST_ADDR_W'(4));
   endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding fetches,
// absorbs wait states and stalls, applies branch redirects and flushes.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STOP_W-1:0]      stall,
   input  logic                   branch_flag,
   input  logic [INST_ADDR_W-1:0] branch_target,
   input  logic                   flush,
   input  logic [INST_ADDR_W-1:0] new_pc,
   output logic                   inst_req,
   output logic [INST_ADDR_W-1:0] inst_addr,
   input  logic                   inst_ack,
   input  logic [INST_W-1:0]      inst_rdata,
   output logic [INST_ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0]      if_inst,
   output logic                   stallreq_if
);

   fetch_state_t state;
   inst_addr_t   pc;
   inst_addr_t   pend_target;
   logic         pend_valid;
   fetch_pair_t  hold_buf;
   inst_addr_t   npc;
   logic         hold;
   logic         unused_stall_bits;

   assign hold              = (stall[0] == Stop);
   assign unused_stall_bits = ^stall[STOP_W-1:1];
   assign npc               = select_next_pc(branch_flag, branch_target, pend_valid, pend_target, pc);
   assign stallreq_if       = (state == FetchReq) && !inst_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FetchIdle;
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= ZeroWord;
         hold_buf    <= '0;
         if_pc       <= ZeroWord;
         if_inst     <= NopInst;
         inst_req    <= 1'b0;
         inst_addr   <= RESET_PC;
      end else begin
         unique case (state)
            FetchIdle: begin
               state    <= FetchReq;
               inst_req <= 1'b1;
               if (flush) begin
                  pc         <= new_pc;
                  inst_addr  <= new_pc;
                  pend_valid <= 1'b0;
                  hold_buf   <= '0;
                  if_pc      <= ZeroWord;
                  if_inst    <= NopInst;
               end else begin
                  inst_addr <= pc;
                  if (branch_flag) begin
                     pend_valid  <= 1'b1;
                     pend_target <= branch_target;
                  end
               end
            end

            FetchReq: begin
               if (flush) begin
                  pc         <= new_pc;
                  pend_valid <= 1'b0;
                  hold_buf   <= '0;
                  if_pc      <= ZeroWord;
                  if_inst    <= NopInst;
                  // An unacked request must still complete on its old address.
                  if (inst_ack) inst_addr <= new_pc;
                  else          state     <= FetchDiscard;
               end else if (inst_ack && !hold) begin
                  if_pc      <= pc;
                  if_inst    <= inst_rdata;
                  pc         <= npc;
                  inst_addr  <= npc;
                  pend_valid <= 1'b0;
               end else if (inst_ack) begin
                  hold_buf <= '{pc: pc, inst: inst_rdata};
                  state    <= FetchHold;
                  inst_req <= 1'b0;
                  if (branch_flag) begin
                     pend_valid  <= 1'b1;
                     pend_target <= branch_target;
                  end
               end else begin
                  if (branch_flag) begin
                     pend_valid  <= 1'b1;
                     pend_target <= branch_target;
                  end
                  if (!hold) begin
                     if_pc   <= ZeroWord;
                     if_inst <= NopInst;
                  end
               end
            end

            FetchDiscard: begin
               if (flush) pc <= new_pc;
               if (inst_ack) begin
                  state     <= FetchReq;
                  inst_addr <= flush ? new_pc : pc;
               end
            end

            FetchHold: begin
               if (flush) begin
                  pc         <= new_pc;
                  inst_addr  <= new_pc;
                  pend_valid <= 1'b0;
                  hold_buf   <= '0;
                  if_pc      <= ZeroWord;
                  if_inst    <= NopInst;
                  state      <= FetchReq;
                  inst_req   <= 1'b1;
               end else if (!hold) begin
                  if_pc      <= hold_buf.pc;
                  if_inst    <= hold_buf.inst;
                  pc         <= npc;
                  inst_addr  <= npc;
                  pend_valid <= 1'b0;
                  state      <= FetchReq;
                  inst_req   <= 1'b1;
               end else if (branch_flag) begin
                  pend_valid  <= 1'b1;
                  pend_target <= branch_target;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a wait-state memory model feeds the DUT,
// expected requests/deliveries are queued per scenario and popped by a monitor.
module tb_pc_fetch;
   import pc_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = '0;
   logic        flush = 1'b0;
   logic [31:0] new_pc = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic [31:0] inst_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq_if;

   int n_checks = 0;
   int n_errors = 0;
   int stall_cycles = 0;
   int waits = 0;
   int wcnt = 0;

   logic [31:0] req_q[$];
   fetch_pair_t dlv_q[$];
   fetch_pair_t last_seen = '0;
   fetch_pair_t exp_pair;

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_flag(branch_flag), .branch_target(branch_target),
      .flush(flush), .new_pc(new_pc),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_ack(inst_ack), .inst_rdata(inst_rdata),
      .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {8'hA5, a[23:0]};
   endfunction

   // Memory: acks after `waits` un-acked request cycles.
   always @(posedge clk) begin
      if (rst)                       wcnt <= 0;
      else if (inst_req && !inst_ack) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
   end
   assign inst_ack   = inst_req && (wcnt >= waits);
   assign inst_rdata = inst_ack ? mem_word(inst_addr) : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (inst_req && inst_ack && req_q.size() > 0)
            check("req_addr", inst_addr, req_q.pop_front());
         if (if_inst != NopInst) begin
            if ({if_pc, if_inst} != last_seen && dlv_q.size() > 0) begin
               exp_pair = dlv_q.pop_front();
               check("dlv_pc", if_pc, exp_pair.pc);
               check("dlv_inst", if_inst, exp_pair.inst);
            end
            last_seen = {if_pc, if_inst};
         end else begin
            last_seen = '0;
         end
         if (stallreq_if) stall_cycles++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic deliver);
      req_q.push_back(a);
      if (deliver) dlv_q.push_back('{pc: a, inst: mem_word(a)});
   endtask

   // Leaves the bench 1 time unit after the last reset edge, rst low (IDLE cycle).
   task automatic do_reset(input int w);
      rst = 1'b1; stall = '0; branch_flag = 1'b0; flush = 1'b0; waits = w;
      req_q.delete(); dlv_q.delete(); stall_cycles = 0; last_seen = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((req_q.size() != 0 || dlv_q.size() != 0) && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({tag, "_req_left"}, 32'(req_q.size()), 32'd0);
      check({tag, "_dlv_left"}, 32'(dlv_q.size()), 32'd0);
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_inst", if_inst, 32'h0);
      check("rst_inst_req", 32'(inst_req), 32'd0);
      check("rst_stallreq", 32'(stallreq_if), 32'd0);
      check("rst_inst_addr", inst_addr, 32'h0);

      // Zero-wait memory with a branch to 0x100 while fetching 0x8
      do_reset(0);
      push(32'h0, 1); push(32'h4, 1); push(32'h8, 1); push(32'h100, 1); push(32'h104, 0);
      @(negedge clk);
      check("idle_no_req", 32'(inst_req), 32'd0);
      tick();
      @(negedge clk);
      check("first_req", 32'(inst_req), 32'd1);
      check("first_addr", inst_addr, 32'h0);
      tick(); tick();
      branch_flag = 1'b1; branch_target = 32'h100;
      tick();
      branch_flag = 1'b0;
      @(negedge clk);
      check("branch_req", inst_addr, 32'h100);
      check("delay_slot_pc", if_pc, 32'h8);
      drain("zero_wait");
      check("zw_stall_cycles", 32'(stall_cycles), 32'd0);

      // Two wait states: stallreq pattern, stable address, bubbles
      do_reset(2);
      push(32'h0, 1); push(32'h4, 1); push(32'h8, 1);
      tick();
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("w2_stallreq", 32'(stallreq_if), (i % 3 != 2) ? 32'd1 : 32'd0);
         check("w2_addr", inst_addr, 32'((i / 3) * 4));
         check("w2_if_inst", if_inst, (i == 3) ? mem_word(32'h0) : (i == 6) ? mem_word(32'h4) : 32'h0);
         tick();
      end
      drain("two_wait");

      // Stall held for 3 cycles when 0xC is acked
      do_reset(0);
      push(32'h0, 1); push(32'h4, 1); push(32'h8, 1); push(32'hC, 1); push(32'h10, 1);
      repeat (4) tick();
      stall = 6'b000001;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) stall = '0;
         @(negedge clk);
         check("hold_no_req", 32'(inst_req), 32'd0);
         check("hold_stallreq", 32'(stallreq_if), 32'd0);
         check("hold_if_pc", if_pc, 32'h8);
      end
      tick();
      @(negedge clk);
      check("release_if_pc", if_pc, 32'hC);
      check("release_req", 32'(inst_req), 32'd1);
      check("release_addr", inst_addr, 32'h10);
      drain("stall_hold");

      // Flush to 0x180 during a 2-wait fetch with a latched branch pending
      do_reset(2);
      push(32'h0, 0); push(32'h180, 1); push(32'h184, 0);
      tick();
      branch_flag = 1'b1; branch_target = 32'h200;
      tick();
      branch_flag = 1'b0; flush = 1'b1; new_pc = 32'h180;
      tick();
      flush = 1'b0;
      @(negedge clk);
      check("discard_req", 32'(inst_req), 32'd1);
      check("discard_old_addr", inst_addr, 32'h0);
      check("flush_bubble", if_inst, 32'h0);
      tick();
      @(negedge clk);
      check("after_discard_addr", inst_addr, 32'h180);
      check("dropped_data", if_inst, 32'h0);
      drain("flush");

      // Reset asserted mid-request while outputs are held by a stall
      do_reset(2);
      push(32'h0, 1); push(32'h4, 1);
      repeat (7) tick();
      stall = 6'b000001;
      tick(); tick();
      @(negedge clk);
      check("pre_rst_if_pc", if_pc, 32'h4);
      rst = 1'b1;
      tick();
      rst = 1'b0; stall = '0;
      @(negedge clk);
      check("mid_rst_if_pc", if_pc, 32'h0);
      check("mid_rst_if_inst", if_inst, 32'h0);
      check("mid_rst_req", 32'(inst_req), 32'd0);
      check("mid_rst_addr", inst_addr, 32'h0);
      check("mid_rst_stallreq", 32'(stallreq_if), 32'd0);
      tick();
      @(negedge clk);
      check("restart_req", 32'(inst_req), 32'd1);
      check("restart_addr", inst_addr, 32'h0);
      drain("mid_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
